opb_register_ppc2simulink_hs: RTL and testbench

OPB slave register that carries data from the PowerPC to user (Simulink) fabric, the write direction of the existing simulink2ppc readback registers. Implements a byte-enabled write/readback DATA word, a STATUS word, and a pending/ack handshake so user logic knows when a fresh value has landed. Sits on the OPB bus in the system wrapper alongside the other software registers. Single clock domain.

---
 rtl/opb_register_ppc2simulink_hs_pkg.sv | 28 ++
 rtl/opb_register_ppc2simulink_hs_if.sv | 27 ++
 rtl/opb_register_ppc2simulink_hs_ack.sv | 71 +++++++
 rtl/opb_register_ppc2simulink_hs.sv | 124 ++++++++++++
 tb/tb_opb_register_ppc2simulink_hs.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/opb_register_ppc2simulink_hs_pkg.sv
// Shared constants for the PPC-to-Simulink OPB register: word offsets, STATUS bits,
// ack FSM states and the byte-lane merge helper.
package opb_reg_pkg;

  localparam logic [2:0] OFF_DATA    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_WRCOUNT = 3'd2;

  localparam int STAT_PENDING_BIT = 31;
  localparam int STAT_OVERRUN_BIT = 30;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_ACK  = 2'd1,
    ACK_HOLD = 2'd2
  } ack_state_e;

  // be[3] is the OPB BE[0] lane, which carries the most significant byte.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    be_merge = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) be_merge[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_hs_if.sv
// OPB slave-side bus bundle for the PPC-to-Simulink register; keeps OPB big-endian bit order.
interface opb_register_ppc2simulink_hs_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [0:AW-1]   OPB_ABus;
  logic [0:DW/8-1] OPB_BE;
  logic [0:DW-1]   OPB_DBus;
  logic            OPB_RNW;
  logic            OPB_select;
  logic            OPB_seqAddr;
  logic [0:DW-1]   Sl_DBus;
  logic            Sl_errAck;
  logic            Sl_retry;
  logic            Sl_toutSup;
  logic            Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_ppc2simulink_hs_ack.sv
// Address decode and IDLE/ACK/HOLD acknowledge FSM: one registered xferAck per select assertion.
module opb_slave_ack
  import opb_reg_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = '0,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  select_i,
  input  logic                  rnw_i,
  input  logic [0:C_OPB_AWIDTH-1] abus_i,
  output logic                  xfer_ack_o,
  output logic                  rd_ack_o,
  output logic                  commit_o,
  output logic [2:0]            word_off_o
);

  ack_state_e              state_q;
  logic                    ack_q;
  logic                    rnw_q;
  logic [2:0]              off_q;
  logic [C_OPB_AWIDTH:0]   lo_diff;
  logic [C_OPB_AWIDTH:0]   hi_diff;
  logic                    hit;

  // Window test via borrow bits so a zero base does not fold into a constant compare.
  assign lo_diff = {1'b0, abus_i} - {1'b0, C_BASEADDR};
  assign hi_diff = {1'b0, C_HIGHADDR} - {1'b0, abus_i};
  assign hit     = select_i && !lo_diff[C_OPB_AWIDTH] && !hi_diff[C_OPB_AWIDTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ACK_IDLE;
      ack_q   <= 1'b0;
      rnw_q   <= 1'b1;
      off_q   <= '0;
    end else begin
      case (state_q)
        ACK_IDLE: begin
          ack_q <= 1'b0;
          if (hit) begin
            state_q <= ACK_ACK;
            ack_q   <= 1'b1;
            rnw_q   <= rnw_i;
            off_q   <= abus_i[C_OPB_AWIDTH-5:C_OPB_AWIDTH-3];
          end
        end
        ACK_ACK: begin
          ack_q   <= 1'b0;
          state_q <= select_i ? ACK_HOLD : ACK_IDLE;
        end
        ACK_HOLD: begin
          ack_q <= 1'b0;
          if (!select_i) state_q <= ACK_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ACK_IDLE;
        end
      endcase
    end
  end

  assign xfer_ack_o = ack_q;
  assign rd_ack_o   = ack_q && rnw_q;
  assign commit_o   = ack_q && !rnw_q;
  assign word_off_o = off_q;

endmodule

// File: rtl/opb_register_ppc2simulink_hs.sv
// OPB slave register carrying PPC data to user fabric with a pending/ack handshake.
// Optional macro OPB_REG_WRCOUNT_EN adds a read-only DATA-write counter at offset 0x08.
module opb_register_ppc2simulink_hs
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_DEFAULT    = 32'h00000000
) (
  input  logic                           OPB_Clk,
  input  logic                           OPB_Rst,
  opb_register_ppc2simulink_hs_if.slave  bus,
  output logic [31:0]                    user_data_out,
  output logic                           user_data_valid,
  output logic                           user_pending,
  input  logic                           user_ack
);

  logic                    commit;
  logic                    rd_ack;
  logic [2:0]              word_off;
  logic [C_OPB_DWIDTH-1:0] wdata;
  logic [3:0]              be;
  logic                    data_commit;
  logic                    stat_clr;
  logic [31:0]             data_q, data_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic                    valid_q, valid_d;
  logic [31:0]             rdata;
  logic                    unused_seqaddr;
`ifdef OPB_REG_WRCOUNT_EN
  logic [31:0]             wrcount_q, wrcount_d;
`endif

  opb_slave_ack #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR)
  ) u_ack (
    .clk_i      (OPB_Clk),
    .rst_n_i    (OPB_Rst),
    .select_i   (bus.OPB_select),
    .rnw_i      (bus.OPB_RNW),
    .abus_i     (bus.OPB_ABus),
    .xfer_ack_o (bus.Sl_xferAck),
    .rd_ack_o   (rd_ack),
    .commit_o   (commit),
    .word_off_o (word_off)
  );

  // Plain vector assignment maps OPB bit 0 onto bit 31 and BE[0] onto be[3].
  assign wdata          = bus.OPB_DBus;
  assign be             = bus.OPB_BE;
  assign unused_seqaddr = bus.OPB_seqAddr;

  assign data_commit = commit && (word_off == OFF_DATA);
  assign stat_clr    = commit && (word_off == OFF_STATUS) && be[3] && wdata[STAT_OVERRUN_BIT];

  always_comb begin
    data_d    = data_commit ? be_merge(data_q, wdata, be) : data_q;
    valid_d   = data_commit;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (data_commit)   pending_d = 1'b1;
    else if (user_ack) pending_d = 1'b0;
    // A same-cycle ack means the user saw the old value, so it is not an overrun.
    if (data_commit && pending_q && !user_ack) overrun_d = 1'b1;
    else if (stat_clr)                         overrun_d = 1'b0;
  end

`ifdef OPB_REG_WRCOUNT_EN
  assign wrcount_d = data_commit ? wrcount_q + 32'd1 : wrcount_q;
`endif

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      data_q    <= C_DEFAULT;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef OPB_REG_WRCOUNT_EN
      wrcount_q <= '0;
`endif
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
`ifdef OPB_REG_WRCOUNT_EN
      wrcount_q <= wrcount_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (word_off)
      OFF_DATA:   rdata = data_q;
      OFF_STATUS: begin
        rdata[STAT_PENDING_BIT] = pending_q;
        rdata[STAT_OVERRUN_BIT] = overrun_q;
      end
`ifdef OPB_REG_WRCOUNT_EN
      OFF_WRCOUNT: rdata = wrcount_q;
`else
      OFF_WRCOUNT: rdata = '0;
`endif
      default:    rdata = '0;
    endcase
  end

  assign bus.Sl_DBus    = rd_ack ? rdata : '0;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

  assign user_data_out   = data_q;
  assign user_data_valid = valid_q;
  assign user_pending    = pending_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink_hs.sv
// Scoreboard bench: transaction-level register model feeds expected acks/valid pulses to a monitor.
module tb_opb_register_ppc2simulink_hs;
  import opb_reg_pkg::*;

  localparam logic [31:0] DEF  = 32'hA5A5A5A5;
  localparam logic [31:0] BASE = 32'h00000000;
  localparam logic [31:0] HIGH = 32'h000000FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] user_data_out;
  logic        user_data_valid;
  logic        user_pending;
  logic        user_ack = 1'b0;
  logic        mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] data_m = DEF;
  bit          pending_m = 1'b0;
  bit          overrun_m = 1'b0;
  logic [31:0] wrcount_m = 32'h0;

  logic [31:0] exp_ack[$];
  logic [32:0] exp_val[$];
  logic [31:0] mon_dbus;

  opb_register_ppc2simulink_hs_if bus ();

  opb_register_ppc2simulink_hs #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_DEFAULT    (DEF)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst_n),
    .bus             (bus),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid),
    .user_pending    (user_pending),
    .user_ack        (user_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return data_m;
      3'd1:    return {pending_m, overrun_m, 30'b0};
`ifdef OPB_REG_WRCOUNT_EN
      3'd2:    return wrcount_m;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents an ack or a valid pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_dbus = bus.Sl_DBus;
      if (bus.Sl_xferAck) begin
        if (exp_ack.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack: got ack with dbus %h expected none", mon_dbus);
        end else begin
          chk("xfer_dbus", mon_dbus, exp_ack.pop_front());
        end
      end else if (mon_dbus != 32'h0) begin
        chk("idle_dbus", mon_dbus, 32'h0);
      end
      if (user_data_valid) begin
        if (exp_val.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid: got valid with data %h expected none", user_data_out);
        end else begin
          logic [32:0] e;
          e = exp_val.pop_front();
          chk("valid_data", user_data_out, e[31:0]);
          chk("valid_pending", {31'b0, user_pending}, {31'b0, e[32]});
        end
      end
    end
  end

  // One OPB transfer; select stays high for 'hold' cycles (>=2) so the master holds data past the ack.
  task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, input bit ack_in_commit);
    bit         hit;
    logic [2:0] off;
    hit = (addr >= BASE) && (addr <= HIGH);
    off = addr[4:2];
    if (hit) begin
      exp_ack.push_back(rnw ? model_read(off) : 32'h0);
      if (!rnw && off == 3'd0) begin
        for (int b = 0; b < 4; b++)
          if (be[3-b]) data_m[31-8*b -: 8] = wd[31-8*b -: 8];
        if (pending_m && !ack_in_commit) overrun_m = 1'b1;
        pending_m = 1'b1;
        wrcount_m = wrcount_m + 32'd1;
        exp_val.push_back({1'b1, data_m});
      end else begin
        if (!rnw && off == 3'd1 && be[3] && wd[30]) overrun_m = 1'b0;
        if (ack_in_commit) pending_m = 1'b0;
      end
    end else if (ack_in_commit) begin
      pending_m = 1'b0;
    end
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = rnw ? 32'h0 : wd;
    bus.OPB_BE     = be;
    bus.OPB_select = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (c == 0) user_ack = ack_in_commit;
      if (c == 1) user_ack = 1'b0;
    end
    bus.OPB_select = 1'b0;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_DBus   = 32'h0;
    bus.OPB_BE     = 4'h0;
    bus.OPB_ABus   = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic ack_pulse();
    user_ack = 1'b1;
    @(posedge clk); #1;
    user_ack = 1'b0;
    pending_m = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addrs [8];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h1C, 32'h20, 32'h100, 32'hFFFF_FFFC};
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_user_data", user_data_out, DEF);
    chk("reset_xferack", {31'b0, bus.Sl_xferAck}, 32'h0);
    chk("reset_pending", {31'b0, user_pending}, 32'h0);
    chk("reset_valid", {31'b0, user_data_valid}, 32'h0);
    mon_dbus = bus.Sl_DBus;
    chk("reset_dbus", mon_dbus, 32'h0);
    chk("tied_zero", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // STATUS = 0
    xfer(32'h00, 1'b0, 32'h12345678, 4'hF, 3, 1'b0);         // full write, pending
    xfer(32'h00, 1'b1, 32'h0, 4'hF, 2, 1'b0);
    xfer(32'h00, 1'b0, 32'hFFFFFFFF, 4'b0010, 2, 1'b0);      // BE[2] lane -> 1234FF78, overrun
    chk("byte_lane", user_data_out, 32'h1234FF78);
    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // C0000000
    xfer(32'h04, 1'b0, 32'h40000000, 4'hF, 2, 1'b0);         // clear overrun
    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // 80000000
    ack_pulse();
    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // 0
    xfer(32'h00, 1'b0, 32'hCAFEF00D, 4'hF, 2, 1'b0);
    xfer(32'h00, 1'b0, 32'h0BADBEEF, 4'hF, 2, 1'b1);         // commit + ack same cycle
    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // 80000000
    chk("same_cycle_pending", {31'b0, user_pending}, 32'h1);
    xfer(32'h100, 1'b1, 32'h0, 4'hF, 3, 1'b0);               // outside: no ack
    xfer(32'h0C, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // ack, 0
    xfer(32'h0C, 1'b0, 32'h55555555, 4'hF, 2, 1'b0);         // ignored
    xfer(32'h00, 1'b0, 32'hFFFFFFFF, 4'h0, 2, 1'b0);         // BE=0 still a write
    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);
    xfer(32'h00, 1'b1, 32'h0, 4'hF, 2, 1'b0);

`ifdef OPB_REG_WRCOUNT_EN
    force dut.wrcount_q = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.wrcount_q;
    wrcount_m = 32'hFFFFFFFF;
    xfer(32'h00, 1'b0, 32'h01020304, 4'hF, 2, 1'b0);
    xfer(32'h08, 1'b1, 32'h0, 4'hF, 2, 1'b0);                // wrapped to 0
`endif

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = addrs[$urandom_range(0, 7)];
      xfer(a, bit'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(2, 4)), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) ack_pulse();
    end
    xfer(32'h04, 1'b1, 32'h0, 4'hF, 2, 1'b0);
    xfer(32'h00, 1'b1, 32'h0, 4'hF, 2, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("acks_outstanding", exp_ack.size(), 32'h0);
    chk("valids_outstanding", exp_val.size(), 32'h0);
    chk("final_data", user_data_out, data_m);
    chk("final_pending", {31'b0, user_pending}, {31'b0, pending_m});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
